grf_sb: RTL and testbench

Parametrised general register file for the pipelined MIPS datapath. It provides N combinational read ports with same-cycle write-to-read bypass and a hardwired zero register. A per-register pending-write scoreboard lets the hazard unit stall on registers with writes still in flight. A registered write-trace port replaces simulation-only print statements in the register file.

---
 rtl/grf_pkg.sv | 9 +
 rtl/grf_sb_cnt.sv | 39 +++
 rtl/grf_sb.sv | 118 +++++++++++
 tb/tb_grf_sb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants for the general register file: default geometry and the
// index of the hardwired zero register.
package grf_pkg;
  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_NUM_RD = 2;
  localparam int GRF_PEND_W = 2;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/grf_sb_cnt.sv
// Saturating pending-write counter for one register. A simultaneous issue and
// write-back cancel out; a lone write-back at zero flags underflow.
module grf_sb_cnt
  import grf_pkg::*;
#(
  parameter int PEND_W = GRF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              at_max,
  output logic              underflow
);

  logic [PEND_W-1:0] cnt_reg;
  logic [PEND_W-1:0] cnt_next;

  assign cnt    = cnt_reg;
  assign at_max = (cnt_reg == {PEND_W{1'b1}});

  always_comb begin
    cnt_next  = cnt_reg;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (!at_max) cnt_next = cnt_reg + PEND_W'(1);
    end else if (dec && !inc) begin
      if (cnt_reg == '0) underflow = 1'b1;
      else               cnt_next  = cnt_reg - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/grf_sb.sv
// Register file with combinational bypassed reads, hardwired zero register,
// per-register pending-write scoreboard and a registered write-trace port.
module grf_sb
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = GRF_NUM_RD,
  parameter int PEND_W = GRF_PEND_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [31:0]              wpc,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic                     trace_valid,
  output logic [31:0]              trace_pc,
  output logic [ADDR_W-1:0]        trace_addr,
  output logic [DATA_W-1:0]        trace_data,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Storage must reset and read combinationally, so it maps to fabric registers.
  logic [DATA_W-1:0]             rf_reg [DEPTH];
  logic [DEPTH-1:0][PEND_W-1:0]  cnt_all;
  logic [DEPTH-1:0]              at_max_all;
  logic [DEPTH-1:0]              underflow_all;
  logic                          wb;
  logic                          iss_acc;
  logic                          sb_err_reg;
  logic [ADDR_W:0]               busy_next;

  assign wb        = we && (wa != ZERO_IDX);
  assign iss_ready = (iss_addr == ZERO_IDX) || !at_max_all[iss_addr];
  assign iss_acc   = iss_valid && iss_ready && (iss_addr != ZERO_IDX);

  assign cnt_all[0]       = '0;
  assign at_max_all[0]    = 1'b0;
  assign underflow_all[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_cnt
      grf_sb_cnt #(.PEND_W(PEND_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (iss_acc && (iss_addr == ADDR_W'(gi))),
        .dec       (wb && (wa == ADDR_W'(gi))),
        .cnt       (cnt_all[gi]),
        .at_max    (at_max_all[gi]),
        .underflow (underflow_all[gi])
      );
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;
      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign hit  = wb && (wa == addr);
      assign rd_data[gi*DATA_W +: DATA_W] =
        (addr == ZERO_IDX) ? '0 : (hit ? wd : rf_reg[addr]);
      // A write landing this cycle retires the last outstanding write early.
      assign rd_ready[gi] = (cnt_all[addr] == '0) ||
                            ((cnt_all[addr] == PEND_W'(1)) && hit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf_reg[i] <= '0;
    end else if (wb) begin
      rf_reg[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      sb_err_reg  <= 1'b0;
    end else begin
      trace_valid <= we;
      if (we) begin
        trace_pc   <= wpc;
        trace_addr <= wa;
        trace_data <= wd;
      end
      sb_err_reg <= sb_err_reg | (|underflow_all);
    end
  end

  assign sb_err = sb_err_reg;

  always_comb begin
    busy_next = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (cnt_all[i] != '0) busy_next = busy_next + (ADDR_W + 1)'(1);
    end
  end

  assign busy_cnt = busy_next;

endmodule

// File: tb/tb_grf_sb.sv
// Directed plus randomized bench for grf_sb against a behavioural model of
// register contents, pending counts, trace and sticky error.
module tb_grf_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] wpc;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [5:0]  busy_cnt;
  logic        sb_err;

  grf_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data), .busy_cnt(busy_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_rf [32];
  int          m_cnt [32];
  bit          m_err;
  bit          m_tv;
  logic [31:0] m_tpc;
  logic [4:0]  m_ta;
  logic [31:0] m_td;

  int vectors = 0;
  int miscompares = 0;
  bit checks_on = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic logic exp_ready(input logic [4:0] a);
    if (a == 0) return 1'b1;
    return (m_cnt[a] == 0) || (m_cnt[a] == 1 && we && wa == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 0; m_tv = 0; m_tpc = '0; m_ta = '0; m_td = '0;
  endtask

  task automatic model_edge();
    bit acc, wbk;
    if (reset) begin
      model_reset();
      return;
    end
    acc = iss_valid && iss_addr != 0 && m_cnt[iss_addr] < 3;
    wbk = we && wa != 0;
    if (wbk) m_rf[wa] = wd;
    m_tv = we;
    if (we) begin m_tpc = wpc; m_ta = wa; m_td = wd; end
    if (!(acc && wbk && iss_addr == wa)) begin
      if (acc) m_cnt[iss_addr]++;
      if (wbk) begin
        if (m_cnt[wa] == 0) m_err = 1;
        else m_cnt[wa]--;
      end
    end
  endtask

  // Inputs are set just after a falling edge; outputs checked 1ns later.
  task automatic step();
    int busy;
    #1;
    if (checks_on) begin
      busy = 0;
      for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) busy++;
      chk("trace_valid", trace_valid, m_tv);
      if (m_tv) begin
        chk("trace_pc", trace_pc, m_tpc);
        chk("trace_addr", trace_addr, m_ta);
        chk("trace_data", trace_data, m_td);
      end
      chk("busy_cnt", busy_cnt, busy);
      chk("sb_err", sb_err, m_err);
      if (!reset) begin
        chk("rd_data0", rd_data[31:0], exp_data(rd_addr[4:0]));
        chk("rd_data1", rd_data[63:32], exp_data(rd_addr[9:5]));
        chk("rd_ready0", rd_ready[0], exp_ready(rd_addr[4:0]));
        chk("rd_ready1", rd_ready[1], exp_ready(rd_addr[9:5]));
        chk("iss_ready", iss_ready, (iss_addr == 0) || (m_cnt[iss_addr] < 3));
      end
    end
    @(posedge clk);
    model_edge();
    checks_on = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; we = 0; wa = 0; wd = 0; wpc = 0; iss_valid = 0; iss_addr = 0;
  endtask

  initial begin
    idle();
    rd_addr = '0;
    reset = 1;
    model_reset();
    @(negedge clk);
    step();
    step();
    idle();

    // All registers read zero after reset
    for (int i = 0; i < 32; i += 2) begin
      rd_addr = {5'(i + 1), 5'(i)};
      step();
    end
    chk("reset_busy", busy_cnt, 0);

    // Bypass and trace
    we = 1; wa = 8; wd = 32'h1234_5678; wpc = 32'h0040_0010; rd_addr = {5'd0, 5'd8};
    #1 chk("bypass_r8", rd_data[31:0], 32'h1234_5678);
    step();
    idle(); rd_addr = {5'd8, 5'd8};
    chk("trace_a8", trace_addr, 5'd8);
    step();

    // Write to zero register
    we = 1; wa = 0; wd = 32'hFFFF_FFFF; wpc = 32'h0040_0014; rd_addr = {5'd0, 5'd0};
    step();
    idle();
    step();

    // Fill reg 5 to saturation, then drain
    iss_valid = 1; iss_addr = 5; rd_addr = {5'd5, 5'd5};
    repeat (4) step();
    iss_valid = 0;
    chk("r5_sat_ready", iss_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      we = 1; wa = 5; wd = 32'hA000_0000 + k; wpc = 32'h100 + 4 * k;
      step();
    end
    idle();
    step();

    // Reg 9: issue then simultaneous issue + write-back
    iss_valid = 1; iss_addr = 9; rd_addr = {5'd10, 5'd9};
    step();
    we = 1; wa = 9; wd = 32'h9999_0000;
    step();
    idle(); rd_addr = {5'd10, 5'd9};
    step();
    // Underflow on reg 10
    we = 1; wa = 10; wd = 32'h1010_1010;
    step();
    idle();
    chk("sb_err_set", sb_err, 1'b1);
    step();
    step();

    // Reset mid-operation with pending counts and a write in flight
    iss_valid = 1; iss_addr = 12;
    step();
    reset = 1; we = 1; wa = 12; wd = 32'hDEAD_BEEF; iss_addr = 13;
    step();
    idle(); rd_addr = {5'd12, 5'd9};
    chk("post_rst_busy", busy_cnt, 0);
    chk("post_rst_err", sb_err, 1'b0);
    step();

    // Randomized traffic over a small register window
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      we        = $urandom_range(0, 1);
      wa        = 5'($urandom_range(0, 7));
      wd        = $urandom;
      wpc       = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_addr  = 5'($urandom_range(0, 7));
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
